// File: rtl/turn_signal_arbiter.sv
// turn_signal_arbiter
//   Arbitrates raw left/right/hazard switch requests into stable left_cmd and
//   right_cmd levels for the tail-light FSM. A grant only changes at a
//   tail-light sequence boundary, so an A->AB->ABC pattern always completes.
//   A grant is held for at least HOLD_SEQS full sequences before it is
//   re-arbitrated.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-low reset
//   tick        one-clk enable pulse from clk_div; gates all state advance
//   left_req    left switch (asynchronous to clk)
//   right_req   right switch (asynchronous to clk)
//   hazard_req  hazard switch (asynchronous to clk)
//   left_cmd    left input of the tail-light FSM
//   right_cmd   right input of the tail-light FSM
//   busy        high while a grant is active
//   phase       tick position within the current sequence, 0..SEQ_TICKS-1
module turn_signal_arbiter #(
  parameter int SEQ_TICKS = 4,
  parameter int HOLD_SEQS = 2,
  parameter int PW        = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          left_req,
  input  logic          right_req,
  input  logic          hazard_req,
  output logic          left_cmd,
  output logic          right_cmd,
  output logic          busy,
  output logic [PW-1:0] phase
);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZARD} state_t;

  localparam int CW = (HOLD_SEQS > 1) ? $clog2(HOLD_SEQS) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(SEQ_TICKS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_SEQS - 1);

  // Request bit order in the synchroniser: {hazard, right, left}
  logic [2:0]    req_p0;
  logic [2:0]    req_p1;
  logic          left_s;
  logic          right_s;
  logic          hazard_s;
  state_t        state;
  state_t        next_grant;
  logic [CW-1:0] seq_cnt;

  function automatic state_t arb(input logic l, input logic r, input logic h);
    if (h || (l && r)) return HAZARD;
    else if (l)        return LEFT;
    else if (r)        return RIGHT;
    else               return IDLE;
  endfunction

  // Stage p0/p1: two-flop synchroniser, runs every clk regardless of tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_p0 <= '0;
      req_p1 <= '0;
    end else begin
      req_p0 <= {hazard_req, right_req, left_req};
      req_p1 <= req_p0;
    end
  end

  assign left_s     = req_p1[0];
  assign right_s    = req_p1[1];
  assign hazard_s   = req_p1[2];
  assign next_grant = arb(left_s, right_s, hazard_s);

  // Grant state machine, advanced only on tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      phase   <= '0;
      seq_cnt <= '0;
    end else if (tick) begin
      if (state == IDLE) begin
        state   <= next_grant;
        phase   <= '0;
        seq_cnt <= '0;
      end else if (phase < PH_LAST) begin
        phase <= phase + 1'b1;
      end else begin
        // Sequence boundary: the only point where the grant may change
        phase <= '0;
        if (seq_cnt < CNT_LAST) begin
          seq_cnt <= seq_cnt + 1'b1;
        end else if (next_grant != state) begin
          state   <= next_grant;
          seq_cnt <= '0;
        end
      end
    end
  end

  // Decoded straight from the state register so an async reset clears them at once
  assign left_cmd  = (state == LEFT)  || (state == HAZARD);
  assign right_cmd = (state == RIGHT) || (state == HAZARD);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_turn_signal_arbiter.sv
// tb_turn_signal_arbiter
//   Directed bench for turn_signal_arbiter with SEQ_TICKS=4, HOLD_SEQS=2 and a
//   tick every 4 clk. Expected outputs are queued when a step is driven and
//   compared when the step completes.
module tb_turn_signal_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       left_req;
  logic       right_req;
  logic       hazard_req;
  logic       left_cmd;
  logic       right_cmd;
  logic       busy;
  logic [1:0] phase;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [4:0] val;  // {left_cmd, right_cmd, busy, phase}
  } exp_t;

  exp_t sb[$];

  turn_signal_arbiter #(.SEQ_TICKS(4), .HOLD_SEQS(2), .PW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .left_req   (left_req),
    .right_req  (right_req),
    .hazard_req (hazard_req),
    .left_cmd   (left_cmd),
    .right_cmd  (right_cmd),
    .busy       (busy),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic l, input logic r,
                      input logic b, input logic [1:0] ph);
    exp_t e;
    e.tag = tag;
    e.val = {l, r, b, ph};
    sb.push_back(e);
  endtask

  task automatic chk();
    exp_t       e;
    logic [4:0] obs;
    e   = sb.pop_front();
    obs = {left_cmd, right_cmd, busy, phase};
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s observed l/r/busy/phase=%b expected=%b", e.tag, obs, e.val);
    end
  endtask

  // One clk with the given tick; returns at the following negedge
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
  endtask

  // One tick period: three quiet clocks then the tick clock
  task automatic tick4();
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic tk(input string tag, input logic l, input logic r,
                    input logic b, input logic [1:0] ph);
    push(tag, l, r, b, ph);
    tick4();
    chk();
  endtask

  initial begin
    reset      = 1'b0;
    tick       = 1'b0;
    left_req   = 1'b1;
    right_req  = 1'b1;
    hazard_req = 1'b1;

    // Reset held with every request active: nothing may come out
    #1;
    push("rst_init", 0, 0, 0, 2'd0);
    chk();
    for (int i = 0; i < 6; i++) begin
      push("rst_hold", 0, 0, 0, 2'd0);
      cyc(logic'(i % 2));
      chk();
    end

    // Release with left only; grant lands on the first tick after sync
    left_req   = 1'b1;
    right_req  = 1'b0;
    hazard_req = 1'b0;
    reset      = 1'b1;
    push("pre_tick", 0, 0, 0, 2'd0);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b0);
    chk();
    push("left_grant", 1, 0, 1, 2'd0);
    cyc(1'b1);
    chk();
    tk("left_ph1", 1, 0, 1, 2'd1);
    tk("left_ph2", 1, 0, 1, 2'd2);
    tk("left_ph3", 1, 0, 1, 2'd3);
    tk("left_ph0", 1, 0, 1, 2'd0);

    // Second sequence with left still held: stays LEFT at the boundary
    tk("left2_ph1", 1, 0, 1, 2'd1);
    tk("left2_ph2", 1, 0, 1, 2'd2);
    tk("left2_ph3", 1, 0, 1, 2'd3);
    tk("left2_stay", 1, 0, 1, 2'd0);

    // Direction change mid-sequence takes effect only at the boundary
    tk("left3_ph1", 1, 0, 1, 2'd1);
    tk("left3_ph2", 1, 0, 1, 2'd2);
    left_req  = 1'b0;
    right_req = 1'b1;
    tk("chg_ph3_left", 1, 0, 1, 2'd3);
    tk("chg_right", 0, 1, 1, 2'd0);

    // Right released: full hold of two sequences, then IDLE
    right_req = 1'b0;
    for (int i = 0; i < 7; i++) tk("right_hold", 0, 1, 1, 2'((i + 1) % 4));
    tk("right_idle", 0, 0, 0, 2'd0);

    // Fresh LEFT grant, request dropped after two ticks, tick frozen at phase 2
    left_req = 1'b1;
    tk("left_b_grant", 1, 0, 1, 2'd0);
    tk("left_b_ph1", 1, 0, 1, 2'd1);
    tk("left_b_ph2", 1, 0, 1, 2'd2);
    left_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i % 25 == 24) push("freeze", 1, 0, 1, 2'd2);
      cyc(1'b0);
      if (i % 25 == 24) chk();
    end
    tk("resume_ph3", 1, 0, 1, 2'd3);
    tk("drop_ph0", 1, 0, 1, 2'd0);
    tk("drop_ph1", 1, 0, 1, 2'd1);
    tk("drop_ph2", 1, 0, 1, 2'd2);
    tk("drop_ph3", 1, 0, 1, 2'd3);
    tk("drop_idle", 0, 0, 0, 2'd0);

    // Left and right together from IDLE give HAZARD
    left_req  = 1'b1;
    right_req = 1'b1;
    tk("lr_hazard", 1, 1, 1, 2'd0);
    left_req  = 1'b0;
    right_req = 1'b0;
    for (int i = 0; i < 7; i++) tk("lr_hold", 1, 1, 1, 2'((i + 1) % 4));
    tk("lr_idle", 0, 0, 0, 2'd0);

    // Hazard during a LEFT grant waits for the hold to expire
    left_req = 1'b1;
    tk("hz_left", 1, 0, 1, 2'd0);
    hazard_req = 1'b1;
    for (int i = 0; i < 7; i++) tk("hz_wait", 1, 0, 1, 2'((i + 1) % 4));
    tk("hz_preempt", 1, 1, 1, 2'd0);

    // Async reset at phase 2 of HAZARD clears outputs without a clock edge
    left_req = 1'b0;
    tk("hz_ph1", 1, 1, 1, 2'd1);
    tk("hz_ph2", 1, 1, 1, 2'd2);
    reset = 1'b0;
    #1;
    push("async_rst", 0, 0, 0, 2'd0);
    chk();
    push("rst_mid", 0, 0, 0, 2'd0);
    cyc(1'b1);
    cyc(1'b1);
    chk();
    reset = 1'b1;
    tk("rst_regrant", 1, 1, 1, 2'd0);
    hazard_req = 1'b0;
    for (int i = 0; i < 7; i++) tk("rst_hold", 1, 1, 1, 2'((i + 1) % 4));
    tk("rst_idle", 0, 0, 0, 2'd0);

    // Tick stuck high: advances every clk after the two-flop sync delay
    left_req = 1'b1;
    push("tk_hi_sync0", 0, 0, 0, 2'd0);
    cyc(1'b1);
    chk();
    push("tk_hi_sync1", 0, 0, 0, 2'd0);
    cyc(1'b1);
    chk();
    push("tk_hi_grant", 1, 0, 1, 2'd0);
    cyc(1'b1);
    chk();
    for (int i = 1; i < 4; i++) begin
      push("tk_hi_ph", 1, 0, 1, 2'(i));
      cyc(1'b1);
      chk();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
